axis_frame_sink: RTL and testbench

AXIS_FRAME_SINK -- requirements
Module: axis_frame_sink

---
 rtl/axis_frame_sink.sv | 174 +++++++++++++++++
 tb/tb_axis_frame_sink.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_sink.sv
// rtl/axis_frame_sink.sv - AXI-Stream video frame sink with framing checks, checksum and frame statistics.
// Optional AXIS_SINK_BACKPRESSURE_EN adds LFSR-driven tready throttling.
module axis_frame_sink #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aclk_reset_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  cfg_enable,
    input  logic [15:0]           cfg_line_beats,
    input  logic [15:0]           cfg_frame_lines,
    input  logic                  stat_clear,
    output logic                  frame_done,
    output logic [31:0]           frame_count,
    output logic [31:0]           frame_checksum,
    output logic                  err_sof,
    output logic                  err_line,
    output logic                  err_frame
);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        IN_LINE  = 2'd1,
        WAIT_SOL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [31:0] csum_q, csum_d;
    logic [31:0] count_q, count_d;
    logic [31:0] fcsum_q, fcsum_d;
    logic        done_q, done_d;
    logic        err_sof_q, err_sof_d;
    logic        err_line_q, err_line_d;
    logic        err_frame_q, err_frame_d;

    logic        throttle;
    logic        accept;
    logic        in_frame;
    logic        sof, eof, sol, eol;
    logic [15:0] base_beat, base_line;
    logic [31:0] base_csum;
    logic [15:0] beats_incl, lines_incl;
    logic [31:0] csum_incl;

`ifdef AXIS_SINK_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign throttle = (lfsr_q[1:0] == 2'b00);
`else
    assign throttle = 1'b0;
`endif

    // Ready is held low during reset even though WAIT_SOF would otherwise follow cfg_enable.
    assign s_axis_tready = aclk_reset_n && !throttle &&
                           ((state_q == WAIT_SOF) ? cfg_enable : 1'b1);

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign in_frame = (state_q != WAIT_SOF);
    assign sof      = s_axis_tuser[0];
    assign eof      = s_axis_tuser[1];
    assign sol      = s_axis_tuser[2];
    assign eol      = s_axis_tuser[3];

    // A SOF beat always restarts the frame as beat 0, whichever state it arrives in.
    assign base_beat  = sof ? 16'd0 : beat_cnt_q;
    assign base_line  = sof ? 16'd0 : line_cnt_q;
    assign base_csum  = sof ? 32'd0 : csum_q;
    assign beats_incl = (base_beat == 16'hFFFF) ? base_beat : base_beat + 16'd1;
    assign lines_incl = !eol ? base_line :
                        ((base_line == 16'hFFFF) ? base_line : base_line + 16'd1);
    assign csum_incl  = base_csum + s_axis_tdata[31:0] + s_axis_tdata[63:32];

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_cnt_d  = line_cnt_q;
        csum_d      = csum_q;
        fcsum_d     = fcsum_q;
        done_d      = 1'b0;
        count_d     = stat_clear ? 32'd0 : count_q;
        err_sof_d   = stat_clear ? 1'b0 : err_sof_q;
        err_line_d  = stat_clear ? 1'b0 : err_line_q;
        err_frame_d = stat_clear ? 1'b0 : err_frame_q;

        if (accept) begin
            if (s_axis_tlast && !eol) begin
                err_line_d = 1'b1;
            end
            if (!in_frame && !sof) begin
                err_sof_d = 1'b1;
            end else begin
                if (in_frame && sof) begin
                    err_sof_d = 1'b1;
                end
                csum_d = csum_incl;
                if (eol) begin
                    if ((beats_incl != cfg_line_beats) || !s_axis_tlast) begin
                        err_line_d = 1'b1;
                    end
                    beat_cnt_d = 16'd0;
                    line_cnt_d = lines_incl;
                end else begin
                    beat_cnt_d = beats_incl;
                end

                if (eof) begin
                    if ((lines_incl != cfg_frame_lines) || !eol) begin
                        err_frame_d = 1'b1;
                    end
                    done_d     = 1'b1;
                    fcsum_d    = csum_incl;
                    count_d    = count_d + 32'd1;
                    state_d    = WAIT_SOF;
                    beat_cnt_d = 16'd0;
                    line_cnt_d = 16'd0;
                    csum_d     = 32'd0;
                end else if (eol) begin
                    state_d = WAIT_SOL;
                end else if (sof || sol || (state_q == IN_LINE)) begin
                    state_d = IN_LINE;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            state_q     <= WAIT_SOF;
            beat_cnt_q  <= 16'd0;
            line_cnt_q  <= 16'd0;
            csum_q      <= 32'd0;
            count_q     <= 32'd0;
            fcsum_q     <= 32'd0;
            done_q      <= 1'b0;
            err_sof_q   <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            line_cnt_q  <= line_cnt_d;
            csum_q      <= csum_d;
            count_q     <= count_d;
            fcsum_q     <= fcsum_d;
            done_q      <= done_d;
            err_sof_q   <= err_sof_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign frame_done     = done_q;
    assign frame_count    = count_q;
    assign frame_checksum = fcsum_q;
    assign err_sof        = err_sof_q;
    assign err_line       = err_line_q;
    assign err_frame      = err_frame_q;

endmodule

// File: tb/tb_axis_frame_sink.sv
// tb/tb_axis_frame_sink.sv - scoreboard bench for axis_frame_sink framing, checksum and error flags.
module tb_axis_frame_sink;

    localparam logic [3:0] U_SOF = 4'b0001;
    localparam logic [3:0] U_EOF = 4'b0010;
    localparam logic [3:0] U_SOL = 4'b0100;
    localparam logic [3:0] U_EOL = 4'b1000;

    logic        aclk = 1'b0;
    logic        aclk_reset_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = 64'd0;
    logic [3:0]  s_axis_tuser = 4'd0;
    logic        s_axis_tlast = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [15:0] cfg_line_beats = 16'd4;
    logic [15:0] cfg_frame_lines = 16'd3;
    logic        stat_clear = 1'b0;
    logic        frame_done;
    logic [31:0] frame_count;
    logic [31:0] frame_checksum;
    logic        err_sof;
    logic        err_line;
    logic        err_frame;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          stalls = 0;
    logic [31:0] exp_q[$];

    axis_frame_sink #(.DATA_WIDTH(64), .USER_WIDTH(4)) dut (
        .aclk            (aclk),
        .aclk_reset_n    (aclk_reset_n),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tlast    (s_axis_tlast),
        .cfg_enable      (cfg_enable),
        .cfg_line_beats  (cfg_line_beats),
        .cfg_frame_lines (cfg_frame_lines),
        .stat_clear      (stat_clear),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .frame_checksum  (frame_checksum),
        .err_sof         (err_sof),
        .err_line        (err_line),
        .err_frame       (err_frame)
    );

    always #5 aclk = ~aclk;

    // Scoreboard: every frame_done pulse must match the oldest expected checksum.
    always @(negedge aclk) begin
        if (frame_done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done checksum=%h (none expected)", frame_checksum);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (frame_checksum !== e) begin
                    errors++;
                    $display("FAIL frame_checksum got=%h exp=%h", frame_checksum, e);
                end
            end
        end
    end

    function automatic logic [63:0] beat_data(input logic [31:0] seed, input int l, input int b);
        logic [31:0] hi, lo;
        if (seed == 32'd0) return 64'h00000001_00000001;
        hi = seed * 32'h9E3779B1 + 32'(l) * 32'h100 + 32'(b);
        lo = ~seed ^ ((32'(l) << 8) | 32'(b));
        return {hi, lo};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [3:0] u, input logic l, input logic clr);
        int waitc;
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        stat_clear    = clr;
        waitc = 0;
        while (s_axis_tready !== 1'b1 && waitc < 200) begin
            @(negedge aclk);
            waitc++;
            stalls++;
        end
        if (waitc >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout tready=%b after %0d cycles (required 1)", s_axis_tready, waitc);
        end
        @(posedge aclk);
        #1 stat_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 4'd0;
        s_axis_tlast  = 1'b0;
        repeat (n) @(negedge aclk);
    endtask

    task automatic clear_stats();
        @(negedge aclk);
        stat_clear = 1'b1;
        @(negedge aclk);
        stat_clear = 1'b0;
    endtask

    // Drives one frame; long_line gets one extra beat; clr_last raises stat_clear with the EOF beat.
    task automatic send_frame(input int nlines, input int nbeats, input int long_line,
                              input logic [31:0] seed, input bit clr_last);
        logic [31:0] sum;
        logic [63:0] d;
        logic [3:0]  u;
        int          nb;
        bit          last_beat;
        sum = 32'd0;
        for (int l = 0; l < nlines; l++) begin
            nb = (l == long_line) ? nbeats + 1 : nbeats;
            for (int b = 0; b < nb; b++) begin
                d = beat_data(seed, l, b);
                sum = sum + d[31:0] + d[63:32];
                u = 4'd0;
                if (b == 0) u = u | U_SOL;
                if (l == 0 && b == 0) u = u | U_SOF;
                if (b == nb - 1) u = u | U_EOL;
                last_beat = (l == nlines - 1) && (b == nb - 1);
                if (last_beat) begin
                    u = u | U_EOF;
                    exp_q.push_back(sum);
                end
                send_beat(d, u, (b == nb - 1), clr_last && last_beat);
            end
        end
    endtask

    task automatic check_flags(input string name, input logic [31:0] cnt,
                               input logic es, input logic el, input logic ef);
        checks++;
        if (frame_count !== cnt) begin
            errors++;
            $display("FAIL %s frame_count got=%0d exp=%0d", name, frame_count, cnt);
        end
        checks++;
        if ({err_sof, err_line, err_frame} !== {es, el, ef}) begin
            errors++;
            $display("FAIL %s err_sof/line/frame got=%b%b%b exp=%b%b%b", name,
                     err_sof, err_line, err_frame, es, el, ef);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_frames got=%0d exp=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        cfg_enable = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if ({s_axis_tready, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready_done got=%b%b exp=00", s_axis_tready, frame_done);
        end
        checks++;
        if (frame_checksum !== 32'd0) begin
            errors++;
            $display("FAIL reset_checksum got=%h exp=0", frame_checksum);
        end
        check_flags("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        aclk_reset_n = 1'b1;
        @(negedge aclk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got=%b exp=1", s_axis_tready);
        end
    endtask

    task automatic test_enable_gate();
        int ready_seen;
        ready_seen = 0;
        @(negedge aclk);
        cfg_enable    = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = U_SOF | U_SOL;
        s_axis_tdata  = 64'h1234;
        repeat (5) begin
            @(negedge aclk);
            if (s_axis_tready !== 1'b0) ready_seen++;
        end
        checks++;
        if (ready_seen != 0) begin
            errors++;
            $display("FAIL enable_gate ready_cycles got=%0d exp=0", ready_seen);
        end
        s_axis_tvalid = 1'b0;
        cfg_enable    = 1'b1;
        idle(2);
        check_flags("enable_gate", 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clean_frame();
        int d0;
        clear_stats();
        d0 = done_cnt;
        send_frame(3, 4, -1, 32'd0, 1'b0);
        idle(3);
        checks++;
        if (frame_checksum !== 32'd24) begin
            errors++;
            $display("FAIL clean_checksum got=%0d exp=24", frame_checksum);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL clean_done_pulses got=%0d exp=1", done_cnt - d0);
        end
        check_flags("clean", 32'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_long_line();
        clear_stats();
        send_frame(3, 4, 1, 32'd5, 1'b0);
        idle(3);
        check_flags("long_line", 32'd1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_short_frame();
        clear_stats();
        send_frame(2, 4, -1, 32'd9, 1'b0);
        idle(3);
        check_flags("short_frame", 32'd1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_sof_errors();
        int d0;
        clear_stats();
        d0 = done_cnt;
        send_beat(64'hDEAD_BEEF_0000_0001, 4'd0, 1'b0, 1'b0);
        idle(2);
        check_flags("stray_beat", 32'd0, 1'b1, 1'b0, 1'b0);
        send_beat(64'h1111_1111_2222_2222, U_SOF | U_SOL, 1'b0, 1'b0);
        send_beat(64'h3333_3333_4444_4444, 4'd0, 1'b0, 1'b0);
        send_frame(3, 4, -1, 32'd11, 1'b0);
        idle(3);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL sof_restart_done_pulses got=%0d exp=1", done_cnt - d0);
        end
        check_flags("sof_restart", 32'd1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_clear_collision();
        send_frame(3, 4, -1, 32'd21, 1'b0);
        idle(2);
        check_flags("pre_collision", 32'd2, 1'b1, 1'b0, 1'b0);
        send_frame(3, 4, -1, 32'd22, 1'b1);
        idle(2);
        check_flags("clear_collision", 32'd1, 1'b0, 1'b0, 1'b0);
        send_frame(2, 4, -1, 32'd23, 1'b1);
        idle(2);
        check_flags("clear_vs_set", 32'd1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        clear_stats();
        send_beat(64'h5555_5555_6666_6666, U_SOF | U_SOL, 1'b0, 1'b0);
        send_beat(64'h7777_7777_8888_8888, 4'd0, 1'b0, 1'b0);
        send_beat(64'h9999_9999_AAAA_AAAA, U_EOL, 1'b0, 1'b0);
        idle(1);
        #2 aclk_reset_n = 1'b0;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ready got=%b exp=0", s_axis_tready);
        end
        check_flags("in_reset", 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge aclk);
        aclk_reset_n = 1'b1;
        send_frame(3, 4, -1, 32'd31, 1'b0);
        idle(3);
        check_flags("reset_mid_frame", 32'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int  d0;
        bit  exp_gaps;
        clear_stats();
        d0 = done_cnt;
        stalls = 0;
`ifdef AXIS_SINK_BACKPRESSURE_EN
        exp_gaps = 1'b1;
`else
        exp_gaps = 1'b0;
`endif
        for (int i = 0; i < 10; i++) begin
            send_frame(3, 4, -1, 32'd100 + 32'(i), 1'b0);
        end
        idle(3);
        checks++;
        if ((stalls > 0) !== exp_gaps) begin
            errors++;
            $display("FAIL ready_gaps got=%0d stalls, gaps_expected=%b", stalls, exp_gaps);
        end
        checks++;
        if (done_cnt - d0 != 10) begin
            errors++;
            $display("FAIL b2b_done_pulses got=%0d exp=10", done_cnt - d0);
        end
        check_flags("back_to_back", 32'd10, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_enable_gate();
        test_clean_frame();
        test_long_line();
        test_short_frame();
        test_sof_errors();
        test_clear_collision();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
